// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYCLES = 0,
    parameter int BUSY_TIMEOUT = 64,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 err_timeout
);
    localparam int CW = $clog2((BUSY_TIMEOUT > GAP_CYCLES ? BUSY_TIMEOUT : GAP_CYCLES) + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, GAP, HOLD} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0] ptr_q, ptr_d, grant_id_q, grant_id_d, win, sel;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic tx_start_q, tx_start_d, grant_valid_q, grant_valid_d, last_q, last_d, err_q, err_d;
    logic lo_done, eval, tmo, start, rel;

    // winner: first pending requester at or after the round-robin pointer
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) win = IDW'((int'(ptr_q) + k) % NUM_REQ);
    end

    // a byte finished when busy falls; the next-byte decision follows the optional gap
    assign lo_done = state_q == WAIT_LO && !tx_busy;
    assign eval    = (lo_done && GAP_CYCLES == 0) || (state_q == GAP && cnt_q == GAP_LAST);
    assign tmo     = state_q == WAIT_HI && !tx_busy && cnt_q == TMO_LAST;
    assign start   = (state_q == IDLE && !tx_busy && |req_valid) ||
                     (((eval && !last_q) || state_q == HOLD) && req_valid[grant_id_q]);
    assign rel     = tmo || (eval && last_q);
    assign sel     = state_q == IDLE ? win : grant_id_q;

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            req_ready_q   <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            last_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            req_ready_q   <= req_ready_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            last_q        <= last_d;
            err_q         <= err_d;
        end
    end

    // next state; the counter restarts on every state change
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = start ? WAIT_HI : IDLE;
            WAIT_HI:      state_d = tx_busy ? WAIT_LO : (tmo ? IDLE : WAIT_HI);
            WAIT_LO, GAP: state_d = (lo_done && GAP_CYCLES > 0) ? GAP :
                                    !eval ? state_q : start ? WAIT_HI : last_q ? IDLE : HOLD;
            HOLD:         state_d = start ? WAIT_HI : HOLD;
            default:      state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    // output and grant bookkeeping
    always_comb begin
        tx_start_d    = start;
        tx_data_d     = start ? req_data[8*sel +: 8] : tx_data_q;
        req_ready_d   = start ? NUM_REQ'(1) << sel : '0;
        grant_id_d    = start ? sel : grant_id_q;
        grant_valid_d = start ? 1'b1 : (rel ? 1'b0 : grant_valid_q);
        last_d        = start ? req_last[sel] : last_q;
        ptr_d         = rel ? (grant_id_q == IDW'(NUM_REQ - 1) ? '0 : grant_id_q + IDW'(1)) : ptr_q;
        err_d         = err_q | tmo;
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign req_ready   = req_ready_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, packet lock, hold, gap, timeout and reset
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int G = 3;
    localparam int T = 16;
    localparam int BYTE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic tx_start, tx_busy, grant_valid, err_timeout;
    logic [7:0] tx_data;
    logic [1:0] grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .BUSY_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_valid(grant_valid),
        .grant_id(grant_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    logic [7:0] data [N][16];
    logic       lst  [N][16];
    int n [N] = '{default: 0};
    int idx [N] = '{default: 0};
    int cyc = 0, busy_cnt = 0, nlog = 0, nfall = 0, viol = 0;
    logic stub = 1'b0;
    logic [7:0] log_d [32];
    int st_cyc [32];
    int fall_cyc [32];
    int pass = 0, tot = 0;

    // requester models: hold a byte until acknowledged
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = idx[i] < n[i];
            req_data[8*i +: 8] = data[i][idx[i][3:0]];
            req_last[i] = lst[i][idx[i][3:0]];
        end
    end

    assign tx_busy = busy_cnt != 0;

    // UART stand-in: busy for BYTE cycles after each start, logs bytes and timing
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                fall_cyc[nfall] <= cyc + 1;
                nfall <= nfall + 1;
            end
        end
        if ((tx_start && tx_busy) || (req_ready != 0 && (!tx_start || $countones(req_ready) != 1)))
            viol <= viol + 1;
        if (tx_start && !stub) begin
            log_d[nlog] <= tx_data;
            st_cyc[nlog] <= cyc;
            nlog <= nlog + 1;
            busy_cnt <= BYTE;
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i]) idx[i] <= idx[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        data[i][n[i]] = d;
        lst[i][n[i]] = l;
        n[i]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int cnt);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (nlog >= cnt && !grant_valid && !tx_busy) break;
        end
        check("wait_log", nlog, cnt);
    endtask

    initial begin
        int s;
        repeat (3) tick();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b0;
        tick();
        // single byte: start and ready one cycle after request
        push(0, 8'h55, 1'b1);
        tick();
        check("single_start", tx_start, 1);
        check("single_ready", req_ready, 4'b0001);
        check("single_data", tx_data, 8'h55);
        check("single_gv", grant_valid, 1);
        tick();
        check("single_start_pulse", tx_start, 0);
        check("single_ready_pulse", req_ready, 0);
        wait_log(1);
        check("single_log", log_d[0], 8'h55);
        check("single_released", grant_valid, 0);
        // fairness with ptr=1: req 2 first
        push(0, 8'h10, 1'b1);
        push(2, 8'h30, 1'b1);
        wait_log(3);
        check("fair1_first", log_d[1], 8'h30);
        check("fair1_second", log_d[2], 8'h10);
        // req 3 alone moves ptr to 0
        push(3, 8'h77, 1'b1);
        wait_log(4);
        check("fair_wrap", log_d[3], 8'h77);
        push(0, 8'h10, 1'b1);
        push(2, 8'h30, 1'b1);
        wait_log(6);
        check("fair0_first", log_d[4], 8'h10);
        check("fair0_second", log_d[5], 8'h30);
        // packet lock: req 1 packet is not interrupted by req 0
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        tick();
        check("pkt_grant_id", grant_id, 1);
        push(0, 8'h5A, 1'b1);
        wait_log(10);
        check("pkt_b0", log_d[6], 8'hA1);
        check("pkt_b1", log_d[7], 8'hA2);
        check("pkt_b2", log_d[8], 8'hA3);
        check("pkt_other", log_d[9], 8'h5A);
        check("gap_in_pkt1", st_cyc[7] - fall_cyc[6], G + 1);
        check("gap_in_pkt2", st_cyc[8] - fall_cyc[7], G + 1);
        check("gap_new_owner", st_cyc[9] - fall_cyc[8], G + 2);
        // hold: req 3 stalls mid-packet, req 0 must wait
        push(3, 8'hB1, 1'b0);
        push(0, 8'hC0, 1'b1);
        repeat (40) tick();
        check("hold_nlog", nlog, 11);
        check("hold_gv", grant_valid, 1);
        check("hold_gid", grant_id, 3);
        check("hold_b1", log_d[10], 8'hB1);
        push(3, 8'hB2, 1'b1);
        wait_log(13);
        check("hold_b2", log_d[11], 8'hB2);
        check("hold_other", log_d[12], 8'hC0);
        // timeout: busy never rises
        stub = 1'b1;
        push(2, 8'hE0, 1'b1);
        tick();
        check("tmo_start", tx_start, 1);
        s = cyc;
        for (int k = 0; k < 40 && !err_timeout; k++) tick();
        check("tmo_err", err_timeout, 1);
        check("tmo_latency", cyc - s, T);
        check("tmo_released", grant_valid, 0);
        stub = 1'b0;
        push(1, 8'hF1, 1'b1);
        wait_log(14);
        check("tmo_recover", log_d[13], 8'hF1);
        check("tmo_sticky", err_timeout, 1);
        // reset mid-byte, then no start until busy falls
        push(3, 8'hD0, 1'b1);
        for (int k = 0; k < 20 && !tx_start; k++) tick();
        check("rstmid_gid", grant_id, 3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_tx_start", tx_start, 0);
        check("rstmid_tx_data", tx_data, 0);
        check("rstmid_ready", req_ready, 0);
        check("rstmid_gv", grant_valid, 0);
        check("rstmid_gid0", grant_id, 0);
        check("rstmid_err", err_timeout, 0);
        rst = 1'b0;
        push(2, 8'hD2, 1'b1);
        wait_log(16);
        check("rstmid_log", log_d[15], 8'hD2);
        check("rstmid_after_busy", st_cyc[15] - fall_cyc[14], 1);
        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `uart` transmitter between `NUM_REQ` byte-stream requesters. It drives the transmitter's `tx_start`/`tx_data` and tracks its `tx_busy`. Multi-byte packets are never interleaved: a grant is held until the requester's last byte is sent. It sits between the system's message sources (status, debug, response channels) and the `uart` instance.

## Interface

- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 0: idle clocks inserted after each byte completes (`tx_busy` falls) before the next `tx_start`.
- `BUSY_TIMEOUT`, 64: clocks allowed from `tx_start` until `tx_busy` is seen high; exceeding it is a fault.
- `IDW`, `$clog2(NUM_REQ)`: width of `grant_id`, minimum 1 (derived).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: requester i has a byte pending. The requester holds `req_valid` and its data stable until `req_ready` is high.
- `req_data`, in, 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last`, in, NUM_REQ: the pending byte is the last of its packet.
- `req_ready`, out, NUM_REQ: one-cycle acknowledge; the byte was accepted.
- `tx_start`, out, 1: one-cycle start pulse to `uart`.
- `tx_data`, out, 8: byte to `uart`; valid while `tx_start` is high and held afterwards.
- `tx_busy`, in, 1: busy flag from `uart`.
- `grant_valid`, out, 1: a requester currently owns the transmitter.
- `grant_id`, out, IDW: current or last owner.
- `err_timeout`, out, 1: sticky; `tx_busy` failed to rise. Cleared only by `rst`.

## Operation

- All outputs are registered.
- States:
  - `IDLE`: no owner.
  - `WAIT_HI`: started, waiting for `tx_busy`=1.
  - `WAIT_LO`: byte in flight.
  - `GAP`: counting `GAP_CYCLES`.
  - `HOLD`: packet open, owner has no byte pending.
- Round-robin pointer `ptr`, reset 0. The winner is the first i with `req_valid[i]`=1, searching `ptr`, `ptr`+1, … mod `NUM_REQ`.
- `IDLE` → `WAIT_HI`: requires `tx_busy`=0 and any `req_valid`. On that edge:
  - `tx_data` ← winner's byte.
  - `tx_start` ← 1.
  - `req_ready[winner]` ← 1.
  - `grant_id` ← winner; `grant_valid` ← 1.
  - `last_q` ← `req_last[winner]`.
- `WAIT_HI`:
  - `tx_busy`=1 → `WAIT_LO`.
  - Counter reaches `BUSY_TIMEOUT` → set `err_timeout`, clear `grant_valid`, `ptr` ← `grant_id`+1, go to `IDLE` (packet abandoned).
- `WAIT_LO`: `tx_busy`=0 → `GAP` if `GAP_CYCLES`>0; otherwise evaluate next-byte immediately.
- `GAP`: after `GAP_CYCLES` clocks, evaluate next-byte.
- Next-byte evaluation:
  - `last_q`=1: clear `grant_valid`, `ptr` ← `grant_id`+1 mod `NUM_REQ`, go to `IDLE`.
  - Else if `req_valid[grant_id]`=1: load and start as in `IDLE`, same owner, go to `WAIT_HI`.
  - Else go to `HOLD`.
- `HOLD`: wait indefinitely for `req_valid[grant_id]`, then load and start. Other requesters are ignored.
- Requests from non-owners are never acknowledged while `grant_valid`=1.
- Simultaneous `req_valid` on several requesters in `IDLE`: exactly one wins, per `ptr`.
- `req_valid` deasserting without `req_ready` is a protocol violation; behaviour is undefined.

## Timing

- Reset values:
  - `tx_start`=0, `tx_data`=0, `req_ready`=0.
  - `grant_valid`=0, `grant_id`=0, `err_timeout`=0.
  - `ptr`=0, state `IDLE`.
- `req_valid` seen at cycle N in `IDLE` with `tx_busy`=0 → `tx_start` and `req_ready` high in cycle N+1 (one cycle each). `req_data` is sampled at the end of cycle N.
- `tx_busy`=0 first seen in `WAIT_LO` at cycle K, owner's next byte valid: next `tx_start` at cycle K+1+`GAP_CYCLES`.
- After a packet ends at cycle K, a new winner's `tx_start` occurs no earlier than K+2+`GAP_CYCLES`, because `IDLE` takes one cycle.
- `tx_start` is never asserted while `tx_busy`=1.
- At most one `req_ready` bit is high per cycle, and only together with `tx_start`.
- Reset mid-byte: outputs return to reset values on the next edge. A byte already in flight in `uart` is not aborted. `IDLE` waits for `tx_busy`=0 before issuing a start.

## Test plan

- **Single byte, loopback.** Uses `uart` at 100 MHz/115200 baud with `tx_out`→`rx_in`. Requester 0 sends 0x55 with `last`=1 → exactly one `tx_start`, `rx_data`=0x55, `grant_valid` falls, `ptr`=1.
- **Fairness.** Requesters 0 and 2 each send a single byte at the same cycle → received order 0x10 (req 0), then 0x30 (req 2). Repeat with `ptr`=1 → req 2's byte first.
- **Packet lock.** Requester 1 sends packet 0xA1, 0xA2, 0xA3 (`last` on 0xA3) while requester 0 holds 0x5A valid → rx order A1, A2, A3, 5A; `req_ready[0]` stays low until A3 completes.
- **HOLD.** Requester 3 drops `req_valid` for 500 cycles mid-packet while requester 0 requests → no `tx_start` during the stall; `grant_id` stays 3; the packet resumes when req 3 asserts again.
- **Timeout.** Stub `tx_busy` tied to 0 → `err_timeout`=1 exactly `BUSY_TIMEOUT` cycles after `tx_start`; grant released. A subsequent request still gets `tx_start`.
- **Gap and reset.** With `GAP_CYCLES`=10, measure 11 cycles from `tx_busy` falling to the next `tx_start`. Assert `rst` mid-byte → all outputs 0 next cycle, and no `tx_start` until `tx_busy` is low.
